// File: rtl/hazard_stall_ctrl.sv
// ID-stage hazard/stall controller: detects load-use and taken-branch hazards and drives the
// control-word bubble select, PC / IF-ID load enables and IF-ID flush; counts bubble cycles.
module hazard_stall_ctrl #(
  parameter int MEM_LAT    = 1,
  parameter int BR_PENALTY = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_load,
  input  logic             ex_rf_en,
  input  logic             id_branch_instr,
  input  logic             id_branch_taken,
  output logic             nop_sel,
  output logic             pc_ld,
  output logic             ifid_ld,
  output logic             ifid_clr,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] LU_STALL = 2'd1;
  localparam logic [1:0] BR_FLUSH = 2'd2;

  // The first bubble/flush happens in RUN, so the counter preload covers the remaining ones.
  localparam int         LU_INIT_I = (MEM_LAT > 1) ? MEM_LAT - 2 : 0;
  localparam int         BR_INIT_I = (BR_PENALTY > 1) ? BR_PENALTY - 2 : 0;
  localparam logic [2:0] LU_INIT   = LU_INIT_I[2:0];
  localparam logic [2:0] BR_INIT   = BR_INIT_I[2:0];
  localparam bit         LU_MULTI  = (MEM_LAT > 1);
  localparam bit         BR_MULTI  = (BR_PENALTY > 1);
  localparam bit         BR_ON     = (BR_PENALTY != 0);

  logic [1:0]       state_reg, state_next;
  logic [2:0]       cnt_reg, cnt_next;
  logic [CNT_W-1:0] stall_cycles_reg;

  logic lu;
  logic bt;
  logic rs1_hit;
  logic rs2_hit;

  logic nop_sel_int;
  logic pc_ld_int;
  logic ifid_ld_int;
  logic ifid_clr_int;

  assign rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);
  assign lu      = ex_load && ex_rf_en && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);
  assign bt      = id_branch_instr && id_branch_taken && BR_ON;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    nop_sel_int  = 1'b0;
    pc_ld_int    = 1'b1;
    ifid_ld_int  = 1'b1;
    ifid_clr_int = 1'b0;
    case (state_reg)
      RUN: begin
        if (lu) begin
          // Load-use wins over a branch: a dependent branch is re-evaluated after the stall.
          nop_sel_int = 1'b1;
          pc_ld_int   = 1'b0;
          ifid_ld_int = 1'b0;
          if (LU_MULTI) begin
            state_next = LU_STALL;
            cnt_next   = LU_INIT;
          end
        end else if (bt) begin
          ifid_clr_int = 1'b1;
          if (BR_MULTI) begin
            state_next = BR_FLUSH;
            cnt_next   = BR_INIT;
          end
        end
      end
      LU_STALL: begin
        nop_sel_int = 1'b1;
        pc_ld_int   = 1'b0;
        ifid_ld_int = 1'b0;
        if (cnt_reg == 3'd0) begin
          state_next = RUN;
        end else begin
          cnt_next = cnt_reg - 3'd1;
        end
      end
      BR_FLUSH: begin
        nop_sel_int  = 1'b1;
        ifid_clr_int = 1'b1;
        if (cnt_reg == 3'd0) begin
          state_next = RUN;
        end else begin
          cnt_next = cnt_reg - 3'd1;
        end
      end
      default: begin
        state_next = RUN;
        cnt_next   = 3'd0;
      end
    endcase
  end

  // Outputs are forced to a safe, squashing value for as long as reset is held.
  assign nop_sel  = reset_n && nop_sel_int;
  assign pc_ld    = reset_n && pc_ld_int;
  assign ifid_ld  = reset_n && ifid_ld_int;
  assign ifid_clr = !reset_n || ifid_clr_int;
  assign busy     = reset_n && (state_reg != RUN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= RUN;
      cnt_reg   <= 3'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles_reg <= '0;
    end else if (nop_sel_int && (stall_cycles_reg != {CNT_W{1'b1}})) begin
      stall_cycles_reg <= stall_cycles_reg + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cycles_reg;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench: instance a (MEM_LAT=1, BR_PENALTY=2, CNT_W=16) and instance b
// (MEM_LAT=3, BR_PENALTY=0, CNT_W=2) share one stimulus stream.
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_load, ex_rf_en;
  logic       id_branch_instr, id_branch_taken;

  logic        a_nop, a_pc, a_ifid_ld, a_clr, a_busy;
  logic [15:0] a_cnt;
  logic        b_nop, b_pc, b_ifid_ld, b_clr, b_busy;
  logic [1:0]  b_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.MEM_LAT(1), .BR_PENALTY(2), .CNT_W(16)) u_a (
    .clk(clk), .reset_n(reset_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_load(ex_load), .ex_rf_en(ex_rf_en),
    .id_branch_instr(id_branch_instr), .id_branch_taken(id_branch_taken),
    .nop_sel(a_nop), .pc_ld(a_pc), .ifid_ld(a_ifid_ld), .ifid_clr(a_clr),
    .busy(a_busy), .stall_cycles(a_cnt)
  );

  hazard_stall_ctrl #(.MEM_LAT(3), .BR_PENALTY(0), .CNT_W(2)) u_b (
    .clk(clk), .reset_n(reset_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_load(ex_load), .ex_rf_en(ex_rf_en),
    .id_branch_instr(id_branch_instr), .id_branch_taken(id_branch_taken),
    .nop_sel(b_nop), .pc_ld(b_pc), .ifid_ld(b_ifid_ld), .ifid_clr(b_clr),
    .busy(b_busy), .stall_cycles(b_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_load = 1'b0; ex_rf_en = 1'b0;
    id_branch_instr = 1'b0; id_branch_taken = 1'b0;
  endtask

  task automatic set_load_use();
    ex_load = 1'b1; ex_rf_en = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    clear_inputs();
    #1;
    // Reset state
    check("rst_a_nop", a_nop, 0);
    check("rst_a_pc", a_pc, 0);
    check("rst_a_ifid_ld", a_ifid_ld, 0);
    check("rst_a_clr", a_clr, 1);
    check("rst_a_busy", a_busy, 0);
    check("rst_a_cnt", a_cnt, 0);
    #3 reset_n = 1'b1;
    tick();
    check("idle_a_nop", a_nop, 0);
    check("idle_a_pc", a_pc, 1);
    check("idle_a_clr", a_clr, 0);

    // No false hazards
    ex_load = 1'b1; ex_rf_en = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1; #1;
    check("nofalse_rd0_a", a_nop, 0);
    check("nofalse_rd0_b", b_nop, 0);
    ex_rd = 5'd7; id_rs1 = 5'd7; ex_rf_en = 1'b0; #1;
    check("nofalse_rfen_a", a_nop, 0);
    ex_rf_en = 1'b1; id_use_rs1 = 1'b0; #1;
    check("nofalse_use_b", b_nop, 0);
    tick();
    check("nofalse_cnt_a", a_cnt, 0);
    check("nofalse_busy_b", b_busy, 0);

    // Load-use: a bubbles once, b bubbles three times
    clear_inputs();
    set_load_use(); #1;
    check("lu1_a_nop", a_nop, 1);
    check("lu1_a_pc", a_pc, 0);
    check("lu1_a_ifid_ld", a_ifid_ld, 0);
    check("lu1_a_clr", a_clr, 0);
    check("lu1_b_nop", b_nop, 1);
    check("lu1_b_busy", b_busy, 0);
    tick();
    clear_inputs(); #1;
    check("lu2_a_nop", a_nop, 0);
    check("lu2_a_pc", a_pc, 1);
    check("lu2_a_busy", a_busy, 0);
    check("lu2_a_cnt", a_cnt, 1);
    check("lu2_b_nop", b_nop, 1);
    check("lu2_b_busy", b_busy, 1);
    check("lu2_b_pc", b_pc, 0);
    check("lu2_b_ifid_ld", b_ifid_ld, 0);
    tick();
    check("lu3_b_nop", b_nop, 1);
    check("lu3_b_busy", b_busy, 1);
    tick();
    check("lu4_b_nop", b_nop, 0);
    check("lu4_b_busy", b_busy, 0);
    check("lu4_b_cnt", b_cnt, 3);
    check("lu4_a_cnt", a_cnt, 1);

    // Taken branch: a flushes two fetches, b (delay slot) never flushes
    id_branch_instr = 1'b1; id_branch_taken = 1'b1; #1;
    check("br1_a_nop", a_nop, 0);
    check("br1_a_clr", a_clr, 1);
    check("br1_a_pc", a_pc, 1);
    check("br1_b_clr", b_clr, 0);
    check("br1_b_nop", b_nop, 0);
    tick();
    clear_inputs(); #1;
    check("br2_a_nop", a_nop, 1);
    check("br2_a_clr", a_clr, 1);
    check("br2_a_ifid_ld", a_ifid_ld, 1);
    check("br2_a_busy", a_busy, 1);
    check("br2_b_clr", b_clr, 0);
    tick();
    check("br3_a_nop", a_nop, 0);
    check("br3_a_clr", a_clr, 0);
    check("br3_a_busy", a_busy, 0);
    check("br3_a_cnt", a_cnt, 2);

    // Load-use and taken branch together: stall first, branch next cycle
    set_load_use(); id_branch_instr = 1'b1; id_branch_taken = 1'b1; #1;
    check("both1_a_nop", a_nop, 1);
    check("both1_a_clr", a_clr, 0);
    check("both1_a_pc", a_pc, 0);
    check("both1_b_clr", b_clr, 0);
    tick();
    check("both1_b_sat", b_cnt, 3);
    check("both1_a_cnt", a_cnt, 3);
    ex_load = 1'b0; #1;
    check("both2_a_nop", a_nop, 0);
    check("both2_a_clr", a_clr, 1);
    check("both2_b_nop", b_nop, 1);
    check("both2_b_clr", b_clr, 0);
    check("both2_b_busy", b_busy, 1);
    tick();
    clear_inputs(); #1;
    check("both3_b_sat", b_cnt, 3);
    check("both3_a_busy", a_busy, 1);
    check("both3_a_nop", a_nop, 1);
    check("both3_a_cnt", a_cnt, 3);

    // Asynchronous reset in the middle of a flush
    #2 reset_n = 1'b0; #1;
    check("midrst_a_nop", a_nop, 0);
    check("midrst_a_pc", a_pc, 0);
    check("midrst_a_ifid_ld", a_ifid_ld, 0);
    check("midrst_a_clr", a_clr, 1);
    check("midrst_a_busy", a_busy, 0);
    check("midrst_a_cnt", a_cnt, 0);
    check("midrst_b_cnt", b_cnt, 0);
    #1 reset_n = 1'b1;
    tick();
    check("post_a_nop", a_nop, 0);
    check("post_a_busy", a_busy, 0);
    check("post_a_clr", a_clr, 0);
    check("post_a_cnt", a_cnt, 0);
    check("post_b_busy", b_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
